// File: rtl/cu_mul_wb.sv
// Multiplier execute/write-back control: two-stage result pipeline,
// register-file write port, operand forwarding and multiplier status flags.
module cu_mul_wb #(
    parameter int RF_DATASIZE = 16,
    parameter int RF_ADDRSIZE = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ps_mul_en,
    input  logic                   ps_mul_otreg,
    input  logic [RF_ADDRSIZE-1:0] ps_cu_rn_addr,
    input  logic [RF_ADDRSIZE-1:0] ps_cu_rx_addr,
    input  logic [RF_ADDRSIZE-1:0] ps_cu_ry_addr,
    input  logic [RF_DATASIZE-1:0] rf_cu_rx,
    input  logic [RF_DATASIZE-1:0] rf_cu_ry,
    input  logic [RF_DATASIZE-1:0] mul_xb_rn,
    input  logic                   mul_ps_ov,
    input  logic                   mul_ps_mn,
    input  logic                   ps_astat_clr,
    output logic [RF_DATASIZE-1:0] xb_cu_rx,
    output logic [RF_DATASIZE-1:0] xb_cu_ry,
    output logic                   cu_rf_wen,
    output logic [RF_ADDRSIZE-1:0] cu_rf_waddr,
    output logic [RF_DATASIZE-1:0] cu_rf_wdata,
    output logic                   ps_mv,
    output logic                   ps_mn,
    output logic                   ps_mos
);

    logic                   r_e_vld;
    logic                   r_e_otreg;
    logic [RF_ADDRSIZE-1:0] r_e_addr;
    logic                   r_w_vld;
    logic [RF_ADDRSIZE-1:0] r_w_addr;
    logic [RF_DATASIZE-1:0] r_w_data;
    logic                   r_mv;
    logic                   r_mn;
    logic                   r_mos;

    logic w_e_wr;
    logic w_e_hit_x;
    logic w_e_hit_y;
    logic w_w_hit_x;
    logic w_w_hit_y;

    // Execute-stage entry is an Rn write whose result is on mul_xb_rn now
    assign w_e_wr    = r_e_vld & ~r_e_otreg;
    assign w_e_hit_x = w_e_wr & (r_e_addr == ps_cu_rx_addr);
    assign w_e_hit_y = w_e_wr & (r_e_addr == ps_cu_ry_addr);
    assign w_w_hit_x = r_w_vld & (r_w_addr == ps_cu_rx_addr);
    assign w_w_hit_y = r_w_vld & (r_w_addr == ps_cu_ry_addr);

    // Execute stage: track the issuing instruction's destination
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e_vld   <= 1'b0;
            r_e_otreg <= 1'b0;
            r_e_addr  <= '0;
        end else begin
            r_e_vld <= ps_mul_en;
            if (ps_mul_en) begin
                r_e_otreg <= ps_mul_otreg;
                r_e_addr  <= ps_cu_rn_addr;
            end
        end
    end

    // Write stage: capture the multiplier result for Rn destinations
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w_vld  <= 1'b0;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else begin
            r_w_vld  <= w_e_wr;
            r_w_addr <= r_e_addr;
            if (w_e_wr) begin
                r_w_data <= mul_xb_rn;
            end
        end
    end

    // Status flags: mv/mn follow each result, mos is sticky with set priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mv  <= 1'b0;
            r_mn  <= 1'b0;
            r_mos <= 1'b0;
        end else begin
            if (r_e_vld) begin
                r_mv <= mul_ps_ov;
                r_mn <= mul_ps_mn;
            end
            if (r_e_vld & mul_ps_ov) begin
                r_mos <= 1'b1;
            end else if (ps_astat_clr) begin
                r_mos <= 1'b0;
            end
        end
    end

    // Operand forwarding: newest in-flight result wins over older ones
    always_comb begin
        xb_cu_rx = rf_cu_rx;
        xb_cu_ry = rf_cu_ry;
        if (w_e_hit_x) begin
            xb_cu_rx = mul_xb_rn;
        end else if (w_w_hit_x) begin
            xb_cu_rx = r_w_data;
        end
        if (w_e_hit_y) begin
            xb_cu_ry = mul_xb_rn;
        end else if (w_w_hit_y) begin
            xb_cu_ry = r_w_data;
        end
    end

    assign cu_rf_wen   = r_w_vld;
    assign cu_rf_waddr = r_w_addr;
    assign cu_rf_wdata = r_w_data;
    assign ps_mv       = r_mv;
    assign ps_mn       = r_mn;
    assign ps_mos      = r_mos;

endmodule

// File: tb/tb_cu_mul_wb.sv
// Directed bench for cu_mul_wb: vector table for pipeline and forwarding,
// hand sequences for flags and mid-pipeline reset.
module tb_cu_mul_wb;

    logic        clk;
    logic        reset;
    logic        ps_mul_en;
    logic        ps_mul_otreg;
    logic [3:0]  ps_cu_rn_addr;
    logic [3:0]  ps_cu_rx_addr;
    logic [3:0]  ps_cu_ry_addr;
    logic [15:0] rf_cu_rx;
    logic [15:0] rf_cu_ry;
    logic [15:0] mul_xb_rn;
    logic        mul_ps_ov;
    logic        mul_ps_mn;
    logic        ps_astat_clr;
    logic [15:0] xb_cu_rx;
    logic [15:0] xb_cu_ry;
    logic        cu_rf_wen;
    logic [3:0]  cu_rf_waddr;
    logic [15:0] cu_rf_wdata;
    logic        ps_mv;
    logic        ps_mn;
    logic        ps_mos;

    int n_chk = 0;
    int n_err = 0;

    cu_mul_wb #(.RF_DATASIZE(16), .RF_ADDRSIZE(4)) dut (
        .clk(clk), .reset(reset),
        .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg),
        .ps_cu_rn_addr(ps_cu_rn_addr),
        .ps_cu_rx_addr(ps_cu_rx_addr), .ps_cu_ry_addr(ps_cu_ry_addr),
        .rf_cu_rx(rf_cu_rx), .rf_cu_ry(rf_cu_ry),
        .mul_xb_rn(mul_xb_rn), .mul_ps_ov(mul_ps_ov), .mul_ps_mn(mul_ps_mn),
        .ps_astat_clr(ps_astat_clr),
        .xb_cu_rx(xb_cu_rx), .xb_cu_ry(xb_cu_ry),
        .cu_rf_wen(cu_rf_wen), .cu_rf_waddr(cu_rf_waddr),
        .cu_rf_wdata(cu_rf_wdata),
        .ps_mv(ps_mv), .ps_mn(ps_mn), .ps_mos(ps_mos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ot;
        logic [3:0]  rn;
        logic [3:0]  rxa;
        logic [15:0] rfx;
        logic [3:0]  rya;
        logic [15:0] rfy;
        logic [15:0] mres;
        logic        wen;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic [15:0] xrx;
        logic [15:0] xry;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(
        logic en, logic ot, logic [3:0] rn,
        logic [3:0] rxa, logic [15:0] rfx,
        logic [3:0] rya, logic [15:0] rfy, logic [15:0] mres,
        logic wen, logic [3:0] waddr, logic [15:0] wdata,
        logic [15:0] xrx, logic [15:0] xry);
        vec_t v;
        v.en = en; v.ot = ot; v.rn = rn;
        v.rxa = rxa; v.rfx = rfx; v.rya = rya; v.rfy = rfy;
        v.mres = mres; v.wen = wen; v.waddr = waddr; v.wdata = wdata;
        v.xrx = xrx; v.xry = xry;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        ps_mul_en     = 1'b0;
        ps_mul_otreg  = 1'b0;
        ps_cu_rn_addr = 4'd0;
        ps_cu_rx_addr = 4'd0;
        ps_cu_ry_addr = 4'd0;
        rf_cu_rx      = 16'h0;
        rf_cu_ry      = 16'h0;
        mul_xb_rn     = 16'h0;
        mul_ps_ov     = 1'b0;
        mul_ps_mn     = 1'b0;
        ps_astat_clr  = 1'b0;
    endtask

    // Advance to just after the next rising edge, inputs default to idle
    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_wen", {31'b0, cu_rf_wen}, 0);
        chk("rst_waddr", {28'b0, cu_rf_waddr}, 0);
        chk("rst_wdata", {16'b0, cu_rf_wdata}, 0);
        chk("rst_flags", {29'b0, ps_mv, ps_mn, ps_mos}, 0);

        vt[0]  = mk(1,0,3, 0,16'h1111, 0,16'h2222, 16'h0000, 0,0,16'h0000, 16'h1111,16'h2222);
        vt[1]  = mk(0,0,0, 3,16'hFFFF, 4,16'h4444, 16'h1234, 0,0,16'h0000, 16'h1234,16'h4444);
        vt[2]  = mk(0,0,0, 3,16'hFFFF, 3,16'hEEEE, 16'hDEAD, 1,3,16'h1234, 16'h1234,16'h1234);
        vt[3]  = mk(0,0,0, 3,16'hFFFF, 3,16'hEEEE, 16'h0000, 0,3,16'h1234, 16'hFFFF,16'hEEEE);
        vt[4]  = mk(1,0,3, 1,16'h0101, 2,16'h0202, 16'h0000, 0,3,16'h1234, 16'h0101,16'h0202);
        vt[5]  = mk(1,0,7, 3,16'hFFFF, 7,16'h0777, 16'h00AA, 0,3,16'h1234, 16'h00AA,16'h0777);
        vt[6]  = mk(0,0,0, 3,16'hFFFF, 7,16'h0777, 16'h0BBB, 1,3,16'h00AA, 16'h00AA,16'h0BBB);
        vt[7]  = mk(0,0,0, 7,16'h1010, 3,16'h3030, 16'h0000, 1,7,16'h0BBB, 16'h0BBB,16'h3030);
        vt[8]  = mk(1,0,5, 5,16'h5555, 0,16'h0000, 16'h0000, 0,7,16'h0BBB, 16'h5555,16'h0000);
        vt[9]  = mk(1,0,5, 5,16'h5555, 5,16'h5555, 16'h0001, 0,7,16'h0BBB, 16'h0001,16'h0001);
        vt[10] = mk(0,0,0, 5,16'h5555, 5,16'h5555, 16'h0002, 1,5,16'h0001, 16'h0002,16'h0002);
        vt[11] = mk(0,0,0, 5,16'h5555, 0,16'h0F0F, 16'h0000, 1,5,16'h0002, 16'h0002,16'h0F0F);
        vt[12] = mk(0,0,0, 5,16'h5555, 0,16'h0F0F, 16'h0000, 0,5,16'h0002, 16'h5555,16'h0F0F);
        vt[13] = mk(1,0,0, 0,16'hAAAA, 5,16'h5555, 16'h0000, 0,5,16'h0002, 16'hAAAA,16'h5555);
        vt[14] = mk(0,0,0, 0,16'hAAAA, 0,16'hBBBB, 16'h0C0C, 0,5,16'h0002, 16'h0C0C,16'h0C0C);
        vt[15] = mk(0,0,0, 0,16'hAAAA, 1,16'h1111, 16'h0000, 1,0,16'h0C0C, 16'h0C0C,16'h1111);

        next_cycle();
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            next_cycle();
            ps_mul_en     = vt[i].en;
            ps_mul_otreg  = vt[i].ot;
            ps_cu_rn_addr = vt[i].rn;
            ps_cu_rx_addr = vt[i].rxa;
            rf_cu_rx      = vt[i].rfx;
            ps_cu_ry_addr = vt[i].rya;
            rf_cu_ry      = vt[i].rfy;
            mul_xb_rn     = vt[i].mres;
            @(negedge clk);
            chk($sformatf("v%0d_wen", i), {31'b0, cu_rf_wen}, {31'b0, vt[i].wen});
            chk($sformatf("v%0d_waddr", i), {28'b0, cu_rf_waddr}, {28'b0, vt[i].waddr});
            chk($sformatf("v%0d_wdata", i), {16'b0, cu_rf_wdata}, {16'b0, vt[i].wdata});
            chk($sformatf("v%0d_xrx", i), {16'b0, xb_cu_rx}, {16'b0, vt[i].xrx});
            chk($sformatf("v%0d_xry", i), {16'b0, xb_cu_ry}, {16'b0, vt[i].xry});
            chk($sformatf("v%0d_flags", i), {29'b0, ps_mv, ps_mn, ps_mos}, 0);
        end

        // MR destination with overflow/negative, then a clean op
        next_cycle();
        ps_mul_en = 1'b1; ps_mul_otreg = 1'b1; ps_cu_rn_addr = 4'd9;
        next_cycle();
        mul_xb_rn = 16'h7777; mul_ps_ov = 1'b1; mul_ps_mn = 1'b1;
        @(negedge clk);
        chk("mr_e_wen", {31'b0, cu_rf_wen}, 0);
        next_cycle();
        ps_mul_en = 1'b1; ps_mul_otreg = 1'b1; ps_cu_rn_addr = 4'd9;
        @(negedge clk);
        chk("mr_flags_set", {29'b0, ps_mv, ps_mn, ps_mos}, 32'h7);
        chk("mr_w_wen", {31'b0, cu_rf_wen}, 0);
        next_cycle();
        mul_xb_rn = 16'h0001;
        @(negedge clk);
        chk("mr2_e_wen", {31'b0, cu_rf_wen}, 0);
        next_cycle();
        @(negedge clk);
        chk("mr_flags_clean", {29'b0, ps_mv, ps_mn, ps_mos}, 32'h1);
        chk("mr2_w_wen", {31'b0, cu_rf_wen}, 0);

        // Clear versus set in the same cycle, then clear alone
        next_cycle();
        ps_astat_clr = 1'b1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("clr_alone_mos", {31'b0, ps_mos}, 0);
        next_cycle();
        ps_mul_en = 1'b1; ps_mul_otreg = 1'b1;
        next_cycle();
        mul_ps_ov = 1'b1; ps_astat_clr = 1'b1;
        next_cycle();
        ps_astat_clr = 1'b1;
        @(negedge clk);
        chk("set_wins_mos", {31'b0, ps_mos}, 1);
        chk("set_wins_mv", {31'b0, ps_mv}, 1);
        next_cycle();
        @(negedge clk);
        chk("clr_after_mos", {31'b0, ps_mos}, 0);
        chk("mv_hold", {31'b0, ps_mv}, 1);

        // Reset one cycle after issue discards the in-flight write
        next_cycle();
        ps_mul_en = 1'b1; ps_cu_rn_addr = 4'd6;
        next_cycle();
        mul_xb_rn = 16'h6666;
        ps_cu_rx_addr = 4'd6; rf_cu_rx = 16'h1357;
        ps_cu_ry_addr = 4'd6; rf_cu_ry = 16'h2468;
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_xrx", {16'b0, xb_cu_rx}, 32'h1357);
        chk("mid_rst_xry", {16'b0, xb_cu_ry}, 32'h2468);
        @(negedge clk);
        chk("mid_rst_wen", {31'b0, cu_rf_wen}, 0);
        chk("mid_rst_flags", {29'b0, ps_mv, ps_mn, ps_mos}, 0);
        chk("mid_rst_wdata", {16'b0, cu_rf_wdata}, 0);
        next_cycle();
        @(negedge clk);
        chk("in_rst_wen", {31'b0, cu_rf_wen}, 0);
        next_cycle();
        reset = 1'b1;
        ps_mul_en = 1'b1; ps_cu_rn_addr = 4'd6;
        @(negedge clk);
        chk("rel_wen", {31'b0, cu_rf_wen}, 0);
        next_cycle();
        mul_xb_rn = 16'h0606;
        @(negedge clk);
        chk("post_e_wen", {31'b0, cu_rf_wen}, 0);
        next_cycle();
        @(negedge clk);
        chk("post_wen", {31'b0, cu_rf_wen}, 1);
        chk("post_waddr", {28'b0, cu_rf_waddr}, 6);
        chk("post_wdata", {16'b0, cu_rf_wdata}, 32'h0606);
        next_cycle();
        @(negedge clk);
        chk("post_wen_off", {31'b0, cu_rf_wen}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
